alu_operand_sequencer: RTL and testbench
========================================

// Module: alu_operand_sequencer
// PURPOSE
//   Upstream operand/opcode sequencer for the trainer's 2-bit ALU.
//   - Steps the user through entering A, B and the opcode on the slide switches,
//     one debounced push-button press per step.
//   - Drives the registered operands to the combinational ALU.
//   - Captures the ALU result into a held display register with a valid flag.
// PARAMETERS
//   WIDTH            2   operand/result width; must equal ALU width; must be >=2
//   SYNC_STAGES      2   flip-flops in the btn_next synchroniser; must be >=2
//   DEBOUNCE_CYCLES  16  consecutive stable synced cycles needed to accept a level change; >=1
// PORTS
//   clk           in   1      system clock; all logic is on the rising edge
//   rst_n         in   1      asynchronous active-low reset
//   sw_data       in   WIDTH  slide switches; operand value, or opcode in [1:0]
//   btn_next      in   1      raw asynchronous push button, active-high
//   alu_result    in   WIDTH  Result returned from the ALU
//   alu_a         out  WIDTH  operand A to the ALU (registered)
//   alu_b         out  WIDTH  operand B to the ALU (registered)
//   alu_op        out  2      opcode to the ALU: 00 AND, 01 OR, 10 ADD, 11 SUB
//   result_q      out  WIDTH  captured ALU result
//   result_valid  out  1      result_q holds the result for the current entry
//   exec_pulse    out  1      one-cycle strobe in the capture cycle
//   state_code    out  3      current FSM state, for the status LEDs
// BEHAVIOUR
//   Reset
//     - All registers, outputs and the debounce counter clear to 0.
//     - FSM enters S_A.
//     - Reset asserted mid-sequence discards any partial entry.
//   Button front end
//     - btn_next passes through SYNC_STAGES flip-flops.
//     - The debounce counter increments each cycle while sync != deb_level.
//       It clears to 0 when they are equal.
//     - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ,
//       deb_level toggles on the next edge and the counter clears.
//     - press = registered rising edge of deb_level; exactly one cycle wide.
//     - A held button gives one press only; a glitch shorter than DEBOUNCE_CYCLES gives none.
//   FSM (state_code values)
//     - S_A=0: on press, a_q <= sw_data; go to S_B.
//     - S_B=1: on press, b_q <= sw_data; go to S_OP.
//     - S_OP=2: on press, op_q <= sw_data[1:0]; go to S_EXEC.
//     - S_EXEC=3: one cycle, no press needed; result_q <= alu_result,
//       result_valid <= 1, exec_pulse = 1; go to S_SHOW.
//     - S_SHOW=4: hold the display; on press, result_valid <= 0; go to S_A.
//     - A press arriving in S_EXEC is ignored and not queued.
//   Outputs and timing
//     - alu_a, alu_b and alu_op are a_q, b_q and op_q, stable between presses.
//     - The ALU is combinational, so alu_result is settled in S_EXEC.
//     - Latency: press to result_q is 2 cycles (S_OP to S_EXEC, then capture).
//   Arithmetic
//     - Wrap-around and overflow are the ALU's modulo-2^WIDTH behaviour; no flags.
//     - result_q is captured unmodified.
//     - Operands are not cleared on a new entry; a_q keeps its old value until
//       overwritten in S_A.
// CONFIGURATION
//   ALU_CHAIN_EN
//     - Defined: a press in S_SHOW loads a_q <= result_q, clears result_valid
//       and goes to S_B. This gives accumulator-style chaining (A is entered
//       only after reset).
//     - Undefined: a press in S_SHOW goes to S_A as described above.
// TESTING
//   Use DEBOUNCE_CYCLES=4 and model the ALU in the bench.
//   1. Reset: hold rst_n=0 then release. state_code=0, all outputs 0,
//      result_valid=0.
//   2. Enter A=2, B=3, op=10. Three clean presses give alu_a=2, alu_b=3,
//      alu_op=2. Two cycles after the 3rd press: result_q=1 (wrap),
//      result_valid=1, and exactly one exec_pulse.
//   3. Debounce: a 3-cycle btn_next glitch gives no state change. A 20-cycle hold
//      gives exactly one advance; releasing the button gives none.
//   4. Subtract: A=1, B=2, op=11 gives result_q=3. A press in S_SHOW returns
//      state_code to 0 and drops result_valid in the same cycle as the state change.
//   5. Reset mid-entry: assert rst_n=0 in S_OP. The FSM returns to S_A, alu_a,
//      alu_b and alu_op are 0, and no exec_pulse occurs.
//   6. ALU_CHAIN_EN: after test 2 (result 1), a press goes to S_B with alu_a=1.
//      Then B=1, op=00 gives result_q=1.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Operand/opcode entry sequencer for the 2-bit ALU trainer: debounced button steps A, B, opcode,
// then captures the ALU result. Define ALU_CHAIN_EN to chain results back into operand A.
module alu_operand_sequencer #(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_data,
  input  logic             btn_next,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] result_q,
  output logic             result_valid,
  output logic             exec_pulse,
  output logic [2:0]       state_code
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic [CW-1:0]          r_deb_cnt;
  logic                   r_deb_level;
  logic                   r_deb_level_d;
  logic                   r_press;

  state_t                 r_state;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic [1:0]             r_op;
  logic [WIDTH-1:0]       r_result;
  logic                   r_valid;
  logic                   r_exec_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_next};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb_cnt     <= '0;
      r_deb_level   <= 1'b0;
      r_deb_level_d <= 1'b0;
      r_press       <= 1'b0;
    end else begin
      r_deb_level_d <= r_deb_level;
      r_press       <= r_deb_level & ~r_deb_level_d;
      if (w_sync != r_deb_level) begin
        if (r_deb_cnt == CNT_MAX) begin
          r_deb_level <= w_sync;
          r_deb_cnt   <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  // A press that lands in S_EXEC is dropped, not queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_A;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_result     <= '0;
      r_valid      <= 1'b0;
      r_exec_pulse <= 1'b0;
    end else begin
      r_exec_pulse <= 1'b0;
      case (r_state)
        S_A: begin
          if (r_press) begin
            r_a     <= sw_data;
            r_state <= S_B;
          end
        end
        S_B: begin
          if (r_press) begin
            r_b     <= sw_data;
            r_state <= S_OP;
          end
        end
        S_OP: begin
          if (r_press) begin
            r_op    <= sw_data[1:0];
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result     <= alu_result;
          r_valid      <= 1'b1;
          r_exec_pulse <= 1'b1;
          r_state      <= S_SHOW;
        end
        S_SHOW: begin
          if (r_press) begin
            r_valid <= 1'b0;
`ifdef ALU_CHAIN_EN
            r_a     <= r_result;
            r_state <= S_B;
`else
            r_state <= S_A;
`endif
          end
        end
        default: r_state <= S_A;
      endcase
    end
  end

  assign alu_a        = r_a;
  assign alu_b        = r_b;
  assign alu_op       = r_op;
  assign result_q     = r_result;
  assign result_valid = r_valid;
  assign exec_pulse   = r_exec_pulse;
  assign state_code   = r_state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer: directed entries, expected results queued at issue,
// checked by a negedge monitor on exec_pulse. Honours ALU_CHAIN_EN.
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sw_data;
  logic       btn_next;
  logic [1:0] alu_result;
  logic [1:0] alu_a;
  logic [1:0] alu_b;
  logic [1:0] alu_op;
  logic [1:0] result_q;
  logic       result_valid;
  logic       exec_pulse;
  logic [2:0] state_code;

  int total = 0;
  int bad   = 0;
  int exec_cnt = 0;
  int exp_q[$];
  int prev_state = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(
    .WIDTH          (2),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_data     (sw_data),
    .btn_next    (btn_next),
    .alu_result  (alu_result),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .result_q    (result_q),
    .result_valid(result_valid),
    .exec_pulse  (exec_pulse),
    .state_code  (state_code)
  );

  // Combinational 2-bit ALU: AND, OR, ADD, SUB, all modulo 4.
  always_comb begin
    case (alu_op)
      2'd0:    alu_result = alu_a & alu_b;
      2'd1:    alu_result = alu_a | alu_b;
      2'd2:    alu_result = alu_a + alu_b;
      default: alu_result = alu_a - alu_b;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (exec_pulse) begin
        exec_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL exec_unexpected: got exec_pulse with result %0d, expected none", result_q);
        end else begin
          chk("result_q", int'(result_q), exp_q.pop_front());
          chk("result_valid_at_exec", int'(result_valid), 1);
          chk("exec_latency_prev_state", prev_state, 3);
        end
      end
      if (prev_state == 4 && state_code != 3'd4)
        chk("valid_drop_with_state", int'(result_valid), 0);
    end
    prev_state = int'(state_code);
  end

  task automatic press(input logic [1:0] val);
    @(negedge clk);
    sw_data  = val;
    btn_next = 1'b1;
    repeat (12) @(negedge clk);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  int e0;
  int st0;

  initial begin
    rst_n    = 1'b0;
    btn_next = 1'b0;
    sw_data  = 2'd0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_state", int'(state_code), 0);
    chk("rst_alu_a", int'(alu_a), 0);
    chk("rst_alu_b", int'(alu_b), 0);
    chk("rst_alu_op", int'(alu_op), 0);
    chk("rst_result_q", int'(result_q), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_exec", int'(exec_pulse), 0);

    // 2 + 3 = 5 -> wraps to 1
    e0 = exec_cnt;
    press(2'd2);
    chk("t2_state_b", int'(state_code), 1);
    chk("t2_alu_a", int'(alu_a), 2);
    press(2'd3);
    chk("t2_state_op", int'(state_code), 2);
    chk("t2_alu_b", int'(alu_b), 3);
    exp_q.push_back(1);
    press(2'd2);
    chk("t2_alu_op", int'(alu_op), 2);
    chk("t2_state_show", int'(state_code), 4);
    chk("t2_result_q", int'(result_q), 1);
    chk("t2_valid", int'(result_valid), 1);
    chk("t2_exec_count", exec_cnt - e0, 1);

`ifdef ALU_CHAIN_EN
    press(2'd0);
    chk("t6_state_b", int'(state_code), 1);
    chk("t6_alu_a_chain", int'(alu_a), 1);
    chk("t6_valid_clear", int'(result_valid), 0);
    press(2'd1);
    chk("t6_alu_b", int'(alu_b), 1);
    exp_q.push_back(1);
    press(2'd0);
    chk("t6_state_show", int'(state_code), 4);
    chk("t6_result_q", int'(result_q), 1);
    press(2'd0);
    chk("t6_state_b_again", int'(state_code), 1);
    st0 = 1;
`else
    press(2'd0);
    chk("show_to_a_state", int'(state_code), 0);
    chk("show_to_a_valid", int'(result_valid), 0);
    st0 = 0;
`endif

    // Short glitch is filtered, long hold advances exactly once
    @(negedge clk);
    sw_data  = (st0 == 1) ? 2'd2 : 2'd1;
    btn_next = 1'b1;
    repeat (3) @(negedge clk);
    btn_next = 1'b0;
    repeat (15) @(negedge clk);
    chk("t3_glitch_state", int'(state_code), st0);
    btn_next = 1'b1;
    repeat (20) @(negedge clk);
    chk("t3_hold_state", int'(state_code), st0 + 1);
    btn_next = 1'b0;
    repeat (20) @(negedge clk);
    chk("t3_release_state", int'(state_code), st0 + 1);

    // 1 - 2 = -1 -> 3
`ifdef ALU_CHAIN_EN
    chk("t4_alu_b", int'(alu_b), 2);
`else
    chk("t4_alu_a", int'(alu_a), 1);
    press(2'd2);
    chk("t4_alu_b", int'(alu_b), 2);
`endif
    exp_q.push_back(3);
    press(2'd3);
    chk("t4_alu_op", int'(alu_op), 3);
    chk("t4_state_show", int'(state_code), 4);
    chk("t4_result_q", int'(result_q), 3);
    press(2'd0);
    chk("t4_state_after_show", int'(state_code), st0);
    chk("t4_valid_after_show", int'(result_valid), 0);

    // Reset while in S_OP
`ifndef ALU_CHAIN_EN
    press(2'd1);
`endif
    press(2'd1);
    chk("t5_in_op", int'(state_code), 2);
    e0 = exec_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_rst_state", int'(state_code), 0);
    chk("t5_rst_alu_a", int'(alu_a), 0);
    chk("t5_rst_alu_b", int'(alu_b), 0);
    chk("t5_rst_alu_op", int'(alu_op), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_state_after", int'(state_code), 0);
    chk("t5_no_exec", exec_cnt - e0, 0);
    chk("t5_result_q", int'(result_q), 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
